// File: rtl/vga_timing_gen_if.sv
// Bus bundle between the VGA timing generator, its framebuffer and the VGA pins.
// The master side is the timing generator: it issues framebuffer reads and drives the pins.
// The slave side returns pixel data and observes the pins.
interface vga_timing_gen_if #(
  parameter int unsigned CNT_W   = 11,
  parameter int unsigned COLOR_W = 4
) ();

  // Framebuffer fetch side
  logic               rd_en;
  logic [CNT_W-1:0]   h_addr;
  logic [CNT_W-1:0]   v_addr;
  logic [31:0]        vga_data;

  // VGA pin side
  logic               hsync;
  logic               vsync;
  logic [COLOR_W-1:0] vga_r;
  logic [COLOR_W-1:0] vga_g;
  logic [COLOR_W-1:0] vga_b;
  logic               de;
  logic               frame_start;
  logic               vblank;

  modport master (
    output rd_en, h_addr, v_addr,
    input  vga_data,
    output hsync, vsync, vga_r, vga_g, vga_b, de, frame_start, vblank
  );

  modport slave (
    input  rd_en, h_addr, v_addr,
    output vga_data,
    input  hsync, vsync, vga_r, vga_g, vga_b, de, frame_start, vblank
  );

endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with framebuffer fetch lookahead.
// Counters drive a combinational fetch stage (rd_en/h_addr/v_addr); sync, de, frame_start and
// vblank are delayed by RD_LATENCY so they line up with the returned pixel, then registered
// together with the colour.
// Optional build macro VGA_TEST_PATTERN_EN adds a test_mode input that replaces framebuffer
// colour with eight vertical bars.
module vga_timing_gen #(
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter bit          HSYNC_POL  = 1'b0,
  parameter bit          VSYNC_POL  = 1'b0,
  parameter int unsigned COLOR_W    = 4,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned CNT_W      = 11
) (
  input  logic             pclk,
  input  logic             reset,
`ifdef VGA_TEST_PATTERN_EN
  input  logic             test_mode,
`endif
  input  logic             en,
  vga_timing_gen_if.master vga
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int unsigned LAST    = RD_LATENCY - 1;

  localparam logic [CNT_W-1:0] H_MAX       = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_MAX       = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYNC_END  = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_END  = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_ACT_START = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] V_ACT_START = CNT_W'(V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] H_ACT_END   = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_END   = CNT_W'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  // ---------------------------------------------------------------------------------------------
  // Raster counters
  // ---------------------------------------------------------------------------------------------
  logic [CNT_W-1:0] hc_q, hc_d;
  logic [CNT_W-1:0] vc_q, vc_d;

  // Next raster position; en low parks the raster at the frame origin.
  always_comb begin
    hc_d = hc_q;
    vc_d = vc_q;
    if (!en) begin
      hc_d = '0;
      vc_d = '0;
    end else if (hc_q == H_MAX) begin
      hc_d = '0;
      vc_d = (vc_q == V_MAX) ? '0 : vc_q + CNT_ONE;
    end else begin
      hc_d = hc_q + CNT_ONE;
    end
  end

  // Raster counter registers.
  always_ff @(posedge pclk) begin
    if (reset) begin
      hc_q <= '0;
      vc_q <= '0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Fetch stage (combinational on the counters)
  // ---------------------------------------------------------------------------------------------
  logic             h_act, v_act, act;
  logic             rd_en;
  logic [CNT_W-1:0] h_off, v_off;
  logic             hs_f, vs_f, de_f, fs_f, vb_f;

  assign h_act = (hc_q >= H_ACT_START) && (hc_q < H_ACT_END);
  assign v_act = (vc_q >= V_ACT_START) && (vc_q < V_ACT_END);
  assign act   = h_act & v_act & en;

  // Modulo-2^CNT_W offsets into the active area; only meaningful while act is high.
  assign h_off = hc_q - H_ACT_START;
  assign v_off = vc_q - V_ACT_START;

`ifdef VGA_TEST_PATTERN_EN
  // Test pattern needs no framebuffer traffic.
  assign rd_en = act & ~test_mode;
`else
  assign rd_en = act;
`endif

  assign vga.rd_en  = rd_en;
  assign vga.h_addr = rd_en ? h_off : '0;
  assign vga.v_addr = rd_en ? v_off : '0;

  // Side-band at the fetch stage; with en low it matches the reset state of the outputs.
  assign hs_f = (en && (hc_q < H_SYNC_END)) ? HSYNC_POL : ~HSYNC_POL;
  assign vs_f = (en && (vc_q < V_SYNC_END)) ? VSYNC_POL : ~VSYNC_POL;
  assign de_f = act;
  assign fs_f = en && (hc_q == '0) && (vc_q == '0);
  assign vb_f = ~(en & v_act);

  // ---------------------------------------------------------------------------------------------
  // Read-latency delay line
  // ---------------------------------------------------------------------------------------------
  logic [RD_LATENCY-1:0] hs_p, vs_p, de_p, fs_p, vb_p;

`ifdef VGA_TEST_PATTERN_EN
  logic [CNT_W-1:0] hx_f;
  logic [CNT_W-1:0] hx_p [RD_LATENCY];

  // Unforced x address follows the pixel even while rd_en is suppressed by test_mode.
  assign hx_f = act ? h_off : '0;
`endif

  // Delay side-band by RD_LATENCY so it meets the pixel returned for the same fetch.
  always_ff @(posedge pclk) begin
    if (reset) begin
      hs_p <= {RD_LATENCY{~HSYNC_POL}};
      vs_p <= {RD_LATENCY{~VSYNC_POL}};
      de_p <= '0;
      fs_p <= '0;
      vb_p <= '1;
`ifdef VGA_TEST_PATTERN_EN
      for (int i = 0; i < RD_LATENCY; i++) begin
        hx_p[i] <= '0;
      end
`endif
    end else begin
      hs_p[0] <= hs_f;
      vs_p[0] <= vs_f;
      de_p[0] <= de_f;
      fs_p[0] <= fs_f;
      vb_p[0] <= vb_f;
      for (int i = 1; i < RD_LATENCY; i++) begin
        hs_p[i] <= hs_p[i-1];
        vs_p[i] <= vs_p[i-1];
        de_p[i] <= de_p[i-1];
        fs_p[i] <= fs_p[i-1];
        vb_p[i] <= vb_p[i-1];
      end
`ifdef VGA_TEST_PATTERN_EN
      hx_p[0] <= hx_f;
      for (int i = 1; i < RD_LATENCY; i++) begin
        hx_p[i] <= hx_p[i-1];
      end
`endif
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Colour select
  // ---------------------------------------------------------------------------------------------
  logic [COLOR_W-1:0] r_d, g_d, b_d;
  logic               unused_data;

  // Bytes outside the top COLOR_W bits of each channel are deliberately dropped.
  assign unused_data = ^vga.vga_data;

`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned BAR_W = CNT_W + 3;
  localparam logic [BAR_W-1:0] BAR_DIV = BAR_W'(H_ACTIVE);

  logic [BAR_W-1:0] bar_num;
  logic [2:0]       bar;

  // Bar index = x * 8 / H_ACTIVE, taken from the delayed address.
  assign bar_num = {hx_p[LAST], 3'b000};
  assign bar     = 3'(bar_num / BAR_DIV);
`endif

  // Colour is only taken while the delayed de is high, so blanking-time data never leaks out.
  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (de_p[LAST]) begin
`ifdef VGA_TEST_PATTERN_EN
      if (test_mode) begin
        r_d = {COLOR_W{bar[2]}};
        g_d = {COLOR_W{bar[1]}};
        b_d = {COLOR_W{bar[0]}};
      end else begin
        r_d = vga.vga_data[23 -: COLOR_W];
        g_d = vga.vga_data[15 -: COLOR_W];
        b_d = vga.vga_data[7 -: COLOR_W];
      end
`else
      r_d = vga.vga_data[23 -: COLOR_W];
      g_d = vga.vga_data[15 -: COLOR_W];
      b_d = vga.vga_data[7 -: COLOR_W];
`endif
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------------------------
  logic               hsync_q, vsync_q, de_q, fs_q, vblank_q;
  logic [COLOR_W-1:0] r_q, g_q, b_q;

  // Register all pin outputs together so sync and colour leave on the same edge.
  always_ff @(posedge pclk) begin
    if (reset) begin
      hsync_q  <= ~HSYNC_POL;
      vsync_q  <= ~VSYNC_POL;
      de_q     <= 1'b0;
      fs_q     <= 1'b0;
      vblank_q <= 1'b1;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
    end else begin
      hsync_q  <= hs_p[LAST];
      vsync_q  <= vs_p[LAST];
      de_q     <= de_p[LAST];
      fs_q     <= fs_p[LAST];
      vblank_q <= vb_p[LAST];
      r_q      <= r_d;
      g_q      <= g_d;
      b_q      <= b_d;
    end
  end

  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.de          = de_q;
  assign vga.frame_start = fs_q;
  assign vga.vblank      = vblank_q;
  assign vga.vga_r       = r_q;
  assign vga.vga_g       = g_q;
  assign vga.vga_b       = b_q;

endmodule
